axis_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges NUM_SRC AXI4-Stream packet sources onto the single AXI4-Stream input of a2sbus, ahead of the dflow pipeline. The grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved. The block also exposes the current grant and a forwarded-packet counter for debug.

---
 rtl/dflow_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/axis_pkt_arbiter.sv | 110 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dflow_pkg.sv
// Shared definitions for the dflow stream blocks: default bus width,
// byte-enable width helper and the arbiter FSM encoding.
package dflow_pkg;

    localparam int DEFAULT_TDATA_WIDTH = 256;

    // One TKEEP bit per data byte.
    function automatic int keep_width(input int tdata_width);
        return tdata_width / 8;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first asserted request
// starting just after the previously served index and wrapping around.
module rr_pick
#(
    parameter int NUM_SRC = 4,
    localparam int SRC_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic               any,
    output logic [SRC_W-1:0]   idx
);

    // Walk last+1 .. last+NUM_SRC modulo NUM_SRC and keep the first hit.
    always_comb begin
        int cand;
        cand = 0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = (int'(last) + k) % NUM_SRC;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXI4-Stream sources onto a
// single stream. A grant is held until the TLAST beat is accepted, so
// packets never interleave. Exposes grant and a packet counter for debug.
module axis_pkt_arbiter
    import dflow_pkg::*;
#(
    parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
    parameter int NUM_SRC = 4,
    localparam int SRC_W = $clog2(NUM_SRC),
    localparam int KEEP_W = keep_width(TDATA_WIDTH)
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NUM_SRC-1:0]             S_AXIS_TVALID,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC*KEEP_W-1:0]      S_AXIS_TKEEP,
    input  logic [NUM_SRC-1:0]             S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]             S_AXIS_TREADY,
    output logic                           M_AXIS_TVALID,
    output logic [TDATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic [KEEP_W-1:0]              M_AXIS_TKEEP,
    output logic                           M_AXIS_TLAST,
    input  logic                           M_AXIS_TREADY,
    output logic                           GRANT_VALID,
    output logic [SRC_W-1:0]               GRANT_ID,
    output logic [31:0]                    PKT_COUNT
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_g;
    logic [31:0]      pkt_count;
    logic             pick_any;
    logic [SRC_W-1:0] pick_idx;
    logic             xfer_last;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req  (S_AXIS_TVALID),
        .last (last_g),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // State register; reset drops straight back to IDLE so every output
    // below goes quiet without waiting for a clock.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture in IDLE, round-robin pointer and packet count on TLAST.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            grant     <= '0;
            last_g    <= SRC_W'(NUM_SRC - 1);
            pkt_count <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant <= pick_idx;
            end
            if (xfer_last) begin
                last_g    <= grant;
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    // Next state plus the zero-latency mux from the granted source.
    always_comb begin
        state_nxt     = state;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        xfer_last     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                M_AXIS_TVALID        = S_AXIS_TVALID[grant];
                M_AXIS_TDATA         = S_AXIS_TDATA[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
                M_AXIS_TKEEP         = S_AXIS_TKEEP[int'(grant)*KEEP_W +: KEEP_W];
                M_AXIS_TLAST         = S_AXIS_TLAST[grant];
                S_AXIS_TREADY[grant] = M_AXIS_TREADY;
                if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
                    xfer_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign GRANT_VALID = (state == BUSY);
    assign GRANT_ID    = grant;
    assign PKT_COUNT   = pkt_count;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: per-source packet queues feed the
// inputs, expected beats are queued in the order they must appear, and an
// independent monitor pops and compares every accepted output beat.
module tb_axis_pkt_arbiter;

    localparam int TDW = 256;
    localparam int NS  = 4;
    localparam int KW  = TDW / 8;
    localparam int SW  = 2;

    typedef struct {
        logic [TDW-1:0] data;
        logic [KW-1:0]  keep;
        logic           last;
        int             gap;
    } beat_t;

    typedef struct {
        int             src;
        logic [TDW-1:0] data;
        logic [KW-1:0]  keep;
        logic           last;
    } exp_t;

    bit                  ACLK;
    logic                ARESET;
    logic [NS-1:0]       S_AXIS_TVALID;
    logic [NS*TDW-1:0]   S_AXIS_TDATA;
    logic [NS*KW-1:0]    S_AXIS_TKEEP;
    logic [NS-1:0]       S_AXIS_TLAST;
    logic [NS-1:0]       S_AXIS_TREADY;
    logic                M_AXIS_TVALID;
    logic [TDW-1:0]      M_AXIS_TDATA;
    logic [KW-1:0]       M_AXIS_TKEEP;
    logic                M_AXIS_TLAST;
    logic                M_AXIS_TREADY;
    logic                GRANT_VALID;
    logic [SW-1:0]       GRANT_ID;
    logic [31:0]         PKT_COUNT;

    beat_t src_q[NS][$];
    exp_t  exp_q[$];
    bit    started[NS];
    int    stall[NS];
    logic [NS-1:0] hs;
    bit    bp_mode;
    bit    bubble_due;
    int    n_compared;
    int    n_mismatched;

    axis_pkt_arbiter #(
        .TDATA_WIDTH (TDW),
        .NUM_SRC     (NS)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .GRANT_VALID   (GRANT_VALID),
        .GRANT_ID      (GRANT_ID),
        .PKT_COUNT     (PKT_COUNT)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Queue one packet on a source; the first exp_beats beats are expected
    // downstream, in call order relative to other packets.
    task automatic applyStimulus(input int src, input int nbeats, input logic [TDW-1:0] base,
                                 input bit vary_keep, input int gap_beat, input int gap_len,
                                 input int exp_beats);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.data = base + TDW'(i);
            b.keep = vary_keep ? (32'hFFFF_FFFF >> (4 * i)) : 32'hFFFF_FFFF;
            b.last = (i == nbeats - 1);
            b.gap  = (i == gap_beat) ? gap_len : 0;
            src_q[src].push_back(b);
            if (i < exp_beats) begin
                e.src  = src;
                e.data = b.data;
                e.keep = b.keep;
                e.last = b.last;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge ACLK);
        #1;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain", TDW'(exp_q.size()), '0);
        waitCycles(2);
    endtask

    task automatic resetDut();
        ARESET = 1'b1;
        waitCycles(2);
        ARESET = 1'b0;
    endtask

    // Source models: drive on the falling edge, note handshakes just before
    // the next rising edge and retire accepted beats.
    initial begin
        beat_t tmp;
        int    cyc;
        cyc           = 0;
        hs            = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b1;
        for (int s = 0; s < NS; s++) begin
            started[s] = 1'b0;
            stall[s]   = 0;
        end
        forever begin
            @(negedge ACLK);
            for (int s = 0; s < NS; s++) begin
                if (hs[s] && src_q[s].size() != 0) begin
                    tmp        = src_q[s].pop_front();
                    started[s] = 1'b0;
                end
                if (src_q[s].size() != 0) begin
                    if (!started[s]) begin
                        started[s] = 1'b1;
                        stall[s]   = src_q[s][0].gap;
                    end
                    if (stall[s] > 0) begin
                        S_AXIS_TVALID[s] = 1'b0;
                        stall[s]--;
                    end else begin
                        S_AXIS_TVALID[s] = 1'b1;
                    end
                    S_AXIS_TDATA[s*TDW +: TDW] = src_q[s][0].data;
                    S_AXIS_TKEEP[s*KW +: KW]   = src_q[s][0].keep;
                    S_AXIS_TLAST[s]            = src_q[s][0].last;
                end else begin
                    S_AXIS_TVALID[s]           = 1'b0;
                    S_AXIS_TDATA[s*TDW +: TDW] = '0;
                    S_AXIS_TKEEP[s*KW +: KW]   = '0;
                    S_AXIS_TLAST[s]            = 1'b0;
                end
            end
            M_AXIS_TREADY = bp_mode ? ((cyc % 2) == 0) : 1'b1;
            cyc++;
            #4;
            hs = S_AXIS_TVALID & S_AXIS_TREADY;
        end
    end

    // Monitor: every accepted output beat is matched against the head of the
    // expected queue; a TLAST acceptance must be followed by an idle cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            #3;
            if (ARESET) begin
                bubble_due = 1'b0;
            end else begin
                if (bubble_due) begin
                    checkOutput("bubble", TDW'({GRANT_VALID, M_AXIS_TVALID}), '0);
                    bubble_due = 1'b0;
                end
                if (bp_mode) begin
                    checkOutput("tready_others", TDW'(S_AXIS_TREADY & 4'b1101), '0);
                    checkOutput("tready_mirror", TDW'(S_AXIS_TREADY[1]), TDW'(M_AXIS_TREADY & GRANT_VALID));
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", TDW'(M_AXIS_TDATA), '0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_src", TDW'(GRANT_ID), TDW'(e.src));
                        checkOutput("beat_data", M_AXIS_TDATA, e.data);
                        checkOutput("beat_keep", TDW'(M_AXIS_TKEEP), TDW'(e.keep));
                        checkOutput("beat_last", TDW'(M_AXIS_TLAST), TDW'(e.last));
                        if (M_AXIS_TLAST) begin
                            bubble_due = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        bp_mode      = 1'b0;
        bubble_due   = 1'b0;
        ARESET       = 1'b1;
        waitCycles(3);
        ARESET = 1'b0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            checkOutput("idle_outputs", TDW'({M_AXIS_TVALID, M_AXIS_TLAST, GRANT_VALID, GRANT_ID,
                                              S_AXIS_TREADY, |M_AXIS_TDATA, |M_AXIS_TKEEP}), '0);
        end
        checkOutput("idle_pkt_count", TDW'(PKT_COUNT), '0);

        $display("[TB] single source, 3 beats");
        applyStimulus(2, 3, TDW'(8'hA1), 1'b0, -1, 0, 3);
        waitCycles(4);
        checkOutput("latency_pending", TDW'(exp_q.size()), TDW'(1));
        waitCycles(1);
        checkOutput("latency_done", TDW'(exp_q.size()), '0);
        checkOutput("single_pkt_count", TDW'(PKT_COUNT), TDW'(1));
        waitCycles(2);

        $display("[TB] all sources, round robin");
        resetDut();
        waitCycles(1);
        applyStimulus(0, 2, TDW'(16'h0100), 1'b1, -1, 0, 2);
        applyStimulus(1, 2, TDW'(16'h1100), 1'b1, -1, 0, 2);
        applyStimulus(2, 2, TDW'(16'h2100), 1'b1, -1, 0, 2);
        applyStimulus(3, 2, TDW'(16'h3100), 1'b1, -1, 0, 2);
        applyStimulus(0, 2, TDW'(16'h0200), 1'b1, -1, 0, 2);
        waitCycles(13);
        checkOutput("round_pkt_count", TDW'(PKT_COUNT), TDW'(4));
        waitDrain(40);
        checkOutput("round2_pkt_count", TDW'(PKT_COUNT), TDW'(5));

        $display("[TB] backpressure on source 1");
        bp_mode = 1'b1;
        applyStimulus(1, 4, TDW'(16'h1400), 1'b1, -1, 0, 4);
        waitDrain(60);
        bp_mode = 1'b0;
        checkOutput("bp_pkt_count", TDW'(PKT_COUNT), TDW'(6));

        $display("[TB] source 3 stalls mid-packet");
        applyStimulus(3, 4, TDW'(16'h3300), 1'b1, 2, 5, 4);
        waitCycles(2);
        applyStimulus(0, 1, TDW'(16'h0500), 1'b0, -1, 0, 1);
        waitCycles(3);
        checkOutput("stall_grant", TDW'({GRANT_VALID, GRANT_ID, M_AXIS_TVALID}), TDW'({1'b1, 2'd3, 1'b0}));
        waitDrain(60);
        checkOutput("stall_pkt_count", TDW'(PKT_COUNT), TDW'(8));

        $display("[TB] reset during a packet");
        applyStimulus(2, 4, TDW'(16'h2500), 1'b1, -1, 0, 1);
        waitCycles(3);
        ARESET = 1'b1;
        src_q[2].delete();
        started[2] = 1'b0;
        #1;
        checkOutput("reset_outputs", TDW'({M_AXIS_TVALID, M_AXIS_TLAST, GRANT_VALID, GRANT_ID,
                                           S_AXIS_TREADY, |M_AXIS_TDATA, |M_AXIS_TKEEP}), '0);
        checkOutput("reset_pkt_count", TDW'(PKT_COUNT), '0);
        checkOutput("reset_truncated", TDW'(exp_q.size()), '0);
        waitCycles(2);
        ARESET = 1'b0;
        applyStimulus(0, 1, TDW'(16'h0600), 1'b0, -1, 0, 1);
        applyStimulus(3, 1, TDW'(16'h3600), 1'b0, -1, 0, 1);
        waitDrain(40);
        checkOutput("post_reset_pkt_count", TDW'(PKT_COUNT), TDW'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
